// File: rtl/ddr_cmd_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ddr_cmd_buffer
// Purpose  : FIFO of four-slot DDR command bundles between execute and PHY.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef BG_WIDTH
`define BG_WIDTH 2
`endif
`ifndef BANK_WIDTH
`define BANK_WIDTH 2
`endif
`ifndef COL_WIDTH
`define COL_WIDTH 10
`endif
`ifndef ROW_WIDTH
`define ROW_WIDTH 17
`endif

module ddr_cmd_buffer #(
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 in_write,
    input  logic [3:0]                 in_read,
    input  logic [3:0]                 in_pre,
    input  logic [3:0]                 in_act,
    input  logic [3:0]                 in_ref,
    input  logic [3:0]                 in_sre,
    input  logic [3:0]                 in_srx,
    input  logic [3:0]                 in_zq,
    input  logic [3:0]                 in_nop,
    input  logic [3:0]                 in_ap,
    input  logic [3:0]                 in_pall,
    input  logic [3:0]                 in_half_bl,
    input  logic [4*`BG_WIDTH-1:0]     in_bg,
    input  logic [4*`BANK_WIDTH-1:0]   in_bank,
    input  logic [4*`COL_WIDTH-1:0]    in_col,
    input  logic [4*`ROW_WIDTH-1:0]    in_row,
    input  logic [511:0]               in_wdata,
    output logic [3:0]                 out_write,
    output logic [3:0]                 out_read,
    output logic [3:0]                 out_pre,
    output logic [3:0]                 out_act,
    output logic [3:0]                 out_ref,
    output logic [3:0]                 out_sre,
    output logic [3:0]                 out_srx,
    output logic [3:0]                 out_zq,
    output logic [3:0]                 out_nop,
    output logic [3:0]                 out_ap,
    output logic [3:0]                 out_pall,
    output logic [3:0]                 out_half_bl,
    output logic [4*`BG_WIDTH-1:0]     out_bg,
    output logic [4*`BANK_WIDTH-1:0]   out_bank,
    output logic [4*`COL_WIDTH-1:0]    out_col,
    output logic [4*`ROW_WIDTH-1:0]    out_row,
    output logic [511:0]               out_wdata,
    output logic                       out_valid,
    input  logic                       phy_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       overflow,
    output logic [CNT_WIDTH-1:0]       issued_cnt,
    output logic [CNT_WIDTH-1:0]       dropped_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef struct packed {
        logic [3:0]               write;
        logic [3:0]               read;
        logic [3:0]               pre;
        logic [3:0]               act;
        logic [3:0]               refresh;
        logic [3:0]               sre;
        logic [3:0]               srx;
        logic [3:0]               zq;
        logic [3:0]               nop;
        logic [3:0]               ap;
        logic [3:0]               pall;
        logic [3:0]               half_bl;
        logic [4*`BG_WIDTH-1:0]   bg;
        logic [4*`BANK_WIDTH-1:0] bank;
        logic [4*`COL_WIDTH-1:0]  col;
        logic [4*`ROW_WIDTH-1:0]  row;
        logic [511:0]             wdata;
    } bundle_t;

    bundle_t mem_q [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0] issued_q, issued_d;
    logic [CNT_WIDTH-1:0] dropped_q, dropped_d;

    bundle_t w_in;
    bundle_t w_head;
    logic    w_valid;
    logic    w_meaningful;
    logic    w_full;
    logic    w_push;
    logic    w_pop;
    logic    w_drop;

    assign w_in = {in_write, in_read, in_pre, in_act, in_ref, in_sre, in_srx,
                   in_zq, in_nop, in_ap, in_pall, in_half_bl,
                   in_bg, in_bank, in_col, in_row, in_wdata};

    // nop/ap/half_bl only qualify other commands, so they never justify a slot
    always_comb begin
        w_meaningful = |{in_write, in_read, in_pre, in_act, in_ref,
                         in_sre, in_srx, in_zq, in_pall};
        w_valid      = (count_q != '0);
        w_full       = (count_q == FULL_OCC);
        w_pop        = w_valid & phy_ready & ~flush;
        w_push       = w_meaningful & ~flush & (~w_full | w_pop);
        w_drop       = w_meaningful & ~flush & w_full & ~w_pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        issued_d   = issued_q;
        dropped_d  = dropped_q;
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (w_push && !w_pop)
                count_d = count_q + OCC_W'(1);
            else if (w_pop && !w_push)
                count_d = count_q - OCC_W'(1);
            if (w_drop) overflow_d = 1'b1;
            if (w_pop)  issued_d   = issued_q + CNT_WIDTH'(1);
            if (w_drop) dropped_d  = dropped_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            issued_q   <= '0;
            dropped_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            issued_q   <= issued_d;
            dropped_q  <= dropped_d;
        end
    end

    // Payload storage is left unreset; stale entries are unreachable once count is zero
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= w_in;
    end

    always_comb begin
        w_head = w_valid ? mem_q[rd_ptr_q] : '0;
    end

    assign out_write   = w_head.write;
    assign out_read    = w_head.read;
    assign out_pre     = w_head.pre;
    assign out_act     = w_head.act;
    assign out_ref     = w_head.refresh;
    assign out_sre     = w_head.sre;
    assign out_srx     = w_head.srx;
    assign out_zq      = w_head.zq;
    assign out_nop     = w_head.nop;
    assign out_ap      = w_head.ap;
    assign out_pall    = w_head.pall;
    assign out_half_bl = w_head.half_bl;
    assign out_bg      = w_head.bg;
    assign out_bank    = w_head.bank;
    assign out_col     = w_head.col;
    assign out_row     = w_head.row;
    assign out_wdata   = w_head.wdata;
    assign out_valid   = w_valid;
    assign occupancy   = count_q;
    assign overflow    = overflow_q;
    assign issued_cnt  = issued_q;
    assign dropped_cnt = dropped_q;

endmodule

`default_nettype wire

// File: doc/ddr_cmd_buffer.md
DDR_CMD_BUFFER -- requirements
Module: ddr_cmd_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving the number of buffered command bundles (power of two, 4..64).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, giving the width of the statistics counters.
REQ-003 SHALL have port clk, input, 1: the single clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have ports in_write, in_read, in_pre, in_act, in_ref, in_sre, in_srx, in_zq, in_nop, in_ap, in_pall, in_half_bl, each input, 4: per-slot command flags from the execute stage.
REQ-006 SHALL have ports in_bg, in_bank, in_col and in_row, all inputs: in_bg is 4*`BG_WIDTH, in_bank is 4*`BANK_WIDTH, in_col is 4*`COL_WIDTH, in_row is 4*`ROW_WIDTH; each carries per-slot addresses.
REQ-007 SHALL have port in_wdata, input, 512: write data for the bundle.
REQ-008 SHALL have output ports out_* matching REQ-005..REQ-007 one-for-one in name suffix and width; these drive the PHY command interface.
REQ-009 SHALL have port out_valid, output, 1: the head bundle is presented.
REQ-010 SHALL have port phy_ready, input, 1: the PHY accepts the head bundle this cycle.
REQ-011 SHALL have port flush, input, 1: synchronous discard of all buffered bundles.
REQ-012 SHALL have ports occupancy (output, $clog2(DEPTH)+1), overflow (output, 1, sticky), issued_cnt (output, CNT_WIDTH) and dropped_cnt (output, CNT_WIDTH).

Function
REQ-013 SHALL treat a bundle as meaningful when any bit of write, read, pre, act, ref, sre, srx, zq or pall is set in any slot; nop, ap and half_bl alone are not meaningful.
REQ-014 SHALL push the input bundle when it is meaningful and a slot is free (occupancy < DEPTH, or a pop happens in the same cycle); non-meaningful bundles are never stored.
REQ-015 SHALL pop the head when out_valid && phy_ready.
REQ-016 SHALL have a minimum latency of one cycle: a bundle pushed at edge N appears on out_* with out_valid=1 after edge N; there is no combinational input-to-output bypass.
REQ-017 SHALL present bundles in strict push order, with all four slots moving together as one entry.
REQ-018 SHALL hold out_* and out_valid stable while out_valid=1 and phy_ready=0.
REQ-019 SHALL drive every out_* bit to 0 when out_valid=0.
REQ-020 SHALL handle a full buffer as follows: if a meaningful bundle arrives with no pop, drop it, set overflow=1, and increment dropped_cnt; if a pop occurs in the same cycle, accept the push and leave occupancy unchanged.
REQ-021 SHALL handle an empty buffer with a simultaneous push by setting occupancy to 1 and making no pop (the head is not yet valid).
REQ-022 SHALL wrap the read and write pointers modulo DEPTH, and occupancy SHALL equal pushes minus pops.
REQ-023 SHALL increment issued_cnt on each pop and dropped_cnt on each drop; both counters wrap at 2^CNT_WIDTH with no saturation.
REQ-024 SHALL, on flush, clear the pointers, occupancy and overflow at the next edge and drive out_valid=0; a push or pop in the same cycle is ignored; issued_cnt and dropped_cnt are retained.
REQ-025 SHALL keep overflow set until rst or flush.

Reset
REQ-026 SHALL, while rst=1, asynchronously force out_valid=0, all out_*=0, occupancy=0, overflow=0, issued_cnt=0, dropped_cnt=0 and pointers=0.
REQ-027 SHALL discard any in-flight bundles when rst is asserted mid-operation; after release, the first push behaves as if into an empty buffer.
REQ-028 SHALL need no storage-array reset; only the state and outputs listed above are reset.

Verification
REQ-029 SHALL pass this scenario: push bundle with in_act=4'b0001, row slot0=0x1234, phy_ready=1 -> next cycle out_valid=1, out_act=4'b0001, out_row slot0=0x1234; one cycle later out_valid=0 and issued_cnt=1.
REQ-030 SHALL pass this scenario: in_nop=4'b1111 with all other flags 0 for 10 cycles -> occupancy stays 0, out_valid=0.
REQ-031 SHALL pass this scenario: phy_ready=0 while pushing 17 meaningful bundles with DEPTH=16 -> occupancy=16, overflow=1, dropped_cnt=1; then phy_ready=1 -> 16 pops in push order, issued_cnt=16.
REQ-032 SHALL pass this scenario: buffer full, push and pop in the same cycle -> occupancy stays 16, overflow stays 0, the new bundle exits 16th.
REQ-033 SHALL pass this scenario: occupancy=5, then flush=1 for one cycle with a concurrent push -> occupancy=0, out_valid=0, overflow=0, counters unchanged.
REQ-034 SHALL pass this scenario: rst asserted mid-burst between clock edges -> outputs zero immediately; after release, a single push appears with 1-cycle latency.
